// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester and RAM-side signals of the VRAM arbiter
// slave modport: arbiter side (slot strobe, video/CPU/DMA requests, RAM data in;
//   returns per-requester dout/ack, registered RAM address/data/we, overrun)
// master modport: the environment driving the arbiter
interface vram_arbiter_if #(parameter int AW = 15);
    logic          ce_slot;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_dout;
    logic          vid_valid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_din;
    logic [7:0]    dma_dout;
    logic          dma_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic          overrun;
    modport slave (
        input  ce_slot, vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
               dma_req, dma_we, dma_addr, dma_din, ram_dout,
        output vid_dout, vid_valid, cpu_dout, cpu_ack, dma_dout, dma_ack,
               ram_addr, ram_din, ram_we, overrun
    );
    modport master (
        output ce_slot, vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
               dma_req, dma_we, dma_addr, dma_din, ram_dout,
        input  vid_dout, vid_valid, cpu_dout, cpu_ack, dma_dout, dma_ack,
               ram_addr, ram_din, ram_we, overrun
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between display fetch, Z80 CPU and DMA
// ports: clk_sys, nRESET (async active-low), bus (vram_arbiter_if.slave) carrying
//   slot strobe, requester handshakes, registered RAM interface and overrun pulse
module vram_arbiter #(
    parameter int AW           = 15,
    parameter int STARVE_LIMIT = 4
) (
    input logic            clk_sys,
    input logic            nRESET,
    vram_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_t;
    state_t        state_q;
    owner_t        owner_q, win;
    logic [CW-1:0] starve_q, starve_d;
    logic [AW-1:0] addr_d, ram_addr_q;
    logic [7:0]    din_d, ram_din_q, vid_dout_q, cpu_dout_q, dma_dout_q;
    logic          we_d, ram_we_q, vid_valid_q, cpu_ack_q, dma_ack_q, overrun_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.vid_dout  = vid_dout_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_dout  = cpu_dout_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_dout  = dma_dout_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.overrun   = overrun_q;
    always_comb begin
        // DMA outranks the CPU only once it has lost STARVE_LIMIT slots in a row
        win = bus.vid_req ? OWN_VID :
              (bus.dma_req && (!bus.cpu_req || starve_q == CW'(STARVE_LIMIT))) ? OWN_DMA :
              bus.cpu_req ? OWN_CPU : OWN_NONE;
        addr_d = win == OWN_VID ? bus.vid_addr : win == OWN_DMA ? bus.dma_addr : bus.cpu_addr;
        din_d  = win == OWN_DMA ? bus.dma_din : bus.cpu_din;
        we_d   = win == OWN_CPU ? bus.cpu_we : (win == OWN_DMA && bus.dma_we);
        // losing to video leaves the count alone; only CPU wins starve DMA
        starve_d = (!bus.dma_req || win == OWN_DMA) ? '0 :
                   (win == OWN_CPU && starve_q != CW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    end
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            vid_dout_q  <= '0;
            cpu_dout_q  <= '0;
            dma_dout_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            overrun_q   <= bus.ce_slot && state_q != IDLE;
            if (!bus.dma_req) starve_q <= '0;
            case (state_q)
                IDLE: if (bus.ce_slot) begin
                    starve_q <= starve_d;
                    if (win != OWN_NONE) begin
                        owner_q    <= win;
                        ram_addr_q <= addr_d;
                        ram_din_q  <= din_d;
                        ram_we_q   <= we_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we_q <= 1'b0;
                    state_q  <= CAPTURE;
                end
                CAPTURE: begin
                    // RAM is write-through, so writes also refresh the owner's dout
                    if (owner_q == OWN_VID) vid_dout_q <= bus.ram_dout;
                    if (owner_q == OWN_CPU) cpu_dout_q <= bus.ram_dout;
                    if (owner_q == OWN_DMA) dma_dout_q <= bus.ram_dout;
                    vid_valid_q <= owner_q == OWN_VID;
                    cpu_ack_q   <= owner_q == OWN_CPU;
                    dma_ack_q   <= owner_q == OWN_DMA;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: slot-level reference model check of vram_arbiter
module tb_vram_arbiter;
    localparam int AW  = 15;
    localparam int LIM = 4;
    localparam int W_NONE = 0, W_VID = 1, W_CPU = 2, W_DMA = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    vram_arbiter_if #(.AW(AW)) bus();
    vram_arbiter #(.AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk_sys(clk),
        .nRESET (rst_n),
        .bus    (bus)
    );
    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a == 15'h1800 ? 8'h5A : a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction
    logic [7:0] mem [0:(1<<AW)-1];
    bit         wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
            wr[bus.ram_addr]  <= 1'b1;
        end
        bus.ram_dout <= bus.ram_we ? bus.ram_din :
                        wr[bus.ram_addr] ? mem[bus.ram_addr] : init_val(bus.ram_addr);
    end
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic [7:0] m_vid, m_cpu, m_dma;
    int starve;
    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_vdout"}, bus.vid_dout, 0);
        chk({tag, "_vvalid"}, bus.vid_valid, 0);
        chk({tag, "_cdout"}, bus.cpu_dout, 0);
        chk({tag, "_cack"}, bus.cpu_ack, 0);
        chk({tag, "_ddout"}, bus.dma_dout, 0);
        chk({tag, "_dack"}, bus.dma_ack, 0);
        chk({tag, "_raddr"}, bus.ram_addr, 0);
        chk({tag, "_rdin"}, bus.ram_din, 0);
        chk({tag, "_rwe"}, bus.ram_we, 0);
        chk({tag, "_ovr"}, bus.overrun, 0);
    endtask
    task automatic model_reset();
        starve = 0;
        m_vid = 0;
        m_cpu = 0;
        m_dma = 0;
    endtask
    // one slot: strobe now (posedge+1), predict winner and data, check the
    // whole gap until the next strobe may be issued
    task automatic slot(input int gap, output int obs);
        int w;
        logic [AW-1:0] a;
        logic [7:0] d, ed;
        logic we;
        if (bus.vid_req) w = W_VID;
        else if (bus.dma_req && (!bus.cpu_req || starve >= LIM)) w = W_DMA;
        else if (bus.cpu_req) w = W_CPU;
        else w = W_NONE;
        if (!bus.dma_req || w == W_DMA) starve = 0;
        else if (w == W_CPU) starve = (starve < LIM) ? starve + 1 : LIM;
        a = w == W_VID ? bus.vid_addr : w == W_DMA ? bus.dma_addr : bus.cpu_addr;
        d = w == W_DMA ? bus.dma_din : bus.cpu_din;
        we = w == W_CPU ? bus.cpu_we : (w == W_DMA && bus.dma_we);
        if (we) ref_mem[a] = d;
        ed = ref_mem[a];
        if (w == W_VID) m_vid = ed;
        if (w == W_CPU) m_cpu = ed;
        if (w == W_DMA) m_dma = ed;
        bus.ce_slot = 1'b1;
        @(posedge clk); #1;
        bus.ce_slot = 1'b0;
        if (w != W_NONE) begin
            chk("ram_addr", bus.ram_addr, a);
            chk("ram_we", bus.ram_we, we);
            if (we) chk("ram_din", bus.ram_din, d);
        end else chk("idle_we", bus.ram_we, 0);
        bus.cpu_addr = AW'($urandom);
        bus.cpu_din  = 8'($urandom);
        bus.cpu_we   = 1'($urandom);
        bus.dma_addr = AW'($urandom);
        bus.dma_din  = 8'($urandom);
        bus.dma_we   = 1'($urandom);
        obs = W_NONE;
        for (int k = 1; k < gap; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("we_drop", bus.ram_we, 0);
            chk("vid_valid", bus.vid_valid, k == 2 && w == W_VID);
            chk("cpu_ack", bus.cpu_ack, k == 2 && w == W_CPU);
            chk("dma_ack", bus.dma_ack, k == 2 && w == W_DMA);
            chk("overrun", bus.overrun, 0);
            if (k == 2) begin
                obs = bus.vid_valid ? W_VID : bus.cpu_ack ? W_CPU : bus.dma_ack ? W_DMA : W_NONE;
                chk("vid_dout", bus.vid_dout, m_vid);
                chk("cpu_dout", bus.cpu_dout, m_cpu);
                chk("dma_dout", bus.dma_dout, m_dma);
            end
        end
    endtask
    initial begin
        int obs, acks, ovs;
        int pat [10] = '{W_CPU, W_CPU, W_CPU, W_CPU, W_DMA, W_CPU, W_CPU, W_CPU, W_CPU, W_DMA};
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
        model_reset();
        bus.ce_slot = 0; bus.vid_req = 0; bus.vid_addr = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_din = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        // display fetch alone
        bus.vid_req = 1; bus.vid_addr = 15'h1800;
        repeat (3) begin
            slot(4, obs);
            chk("vid_only_owner", obs, W_VID);
        end
        chk("vid_5a", bus.vid_dout, 8'h5A);
        // video beats CPU, CPU served next slot
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h4000;
        slot(4, obs);
        chk("cont_vid", obs, W_VID);
        bus.vid_req = 0;
        bus.cpu_we = 0; bus.cpu_addr = 15'h4000;
        slot(4, obs);
        chk("cont_cpu", obs, W_CPU);
        chk("cont_data", bus.cpu_dout, init_val(15'h4000));
        // write then readback
        bus.cpu_we = 1; bus.cpu_addr = 15'h2345; bus.cpu_din = 8'hA7;
        slot(4, obs);
        bus.cpu_we = 0; bus.cpu_addr = 15'h2345;
        slot(4, obs);
        chk("readback", bus.cpu_dout, 8'hA7);
        // starvation with CPU and DMA held
        bus.dma_req = 1;
        for (int i = 0; i < 10; i++) begin
            slot(3, obs);
            chk($sformatf("starve_%0d", i), obs, pat[i]);
        end
        for (int i = 0; i < 12; i++) begin
            bus.vid_req = (i % 2 == 0);
            slot(3, obs);
        end
        bus.vid_req = 0; bus.dma_req = 0;
        bus.cpu_req = 0;
        slot(3, obs);
        // reset in the middle of a CPU write
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0123; bus.cpu_din = 8'h99;
        bus.ce_slot = 1;
        @(posedge clk); #1;
        bus.ce_slot = 0;
        chk("rst_we_before", bus.ram_we, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_ack", bus.cpu_ack, 0);
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        slot(4, obs);
        chk("rst_regrant", obs, W_CPU);
        bus.cpu_req = 0;
        // strobes two clocks apart
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0200;
        bus.ce_slot = 1;
        @(posedge clk); #1;
        bus.ce_slot = 0;
        @(posedge clk); #1;
        bus.ce_slot = 1;
        @(posedge clk); #1;
        bus.ce_slot = 0;
        chk("ovr_pulse", bus.overrun, 1);
        chk("ovr_first_ack", bus.cpu_ack, 1);
        chk("ovr_dout", bus.cpu_dout, ref_mem[15'h0200]);
        m_cpu = ref_mem[15'h0200];
        acks = int'(bus.cpu_ack);
        ovs = int'(bus.overrun);
        bus.cpu_req = 0;
        repeat (4) begin
            @(posedge clk); #1;
            acks += int'(bus.cpu_ack);
            ovs += int'(bus.overrun);
        end
        chk("ovr_acks", acks, 1);
        chk("ovr_count", ovs, 1);
        // randomized traffic over a small address window
        for (int i = 0; i < 300; i++) begin
            bus.vid_req  = ($urandom_range(0, 3) == 0);
            bus.cpu_req  = ($urandom_range(0, 3) != 0);
            bus.dma_req  = ($urandom_range(0, 3) != 0);
            bus.vid_addr = AW'(15'h0100 + $urandom_range(0, 15));
            bus.cpu_addr = AW'(15'h0100 + $urandom_range(0, 15));
            bus.dma_addr = AW'(15'h0100 + $urandom_range(0, 15));
            bus.cpu_we   = 1'($urandom);
            bus.dma_we   = 1'($urandom);
            bus.cpu_din  = 8'($urandom);
            bus.dma_din  = 8'($urandom);
            slot($urandom_range(3, 5), obs);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
